fifo_flow: RTL and testbench
============================

// Module: fifo_flow
// PURPOSE
//  Parametrised single-clock FIFO, successor to the basic sync-BRAM FIFO. Selectable FWFT/standard read mode.
//  Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush.
//  Backed by the shared single-port-write/sync-read bram (1-cycle read latency); used for stream buffering in datapaths.
// PARAMETERS
//  FWFT          1     1: first-word-fall-through (dout valid while dvld=1); 0: standard (dout valid 1 cycle after rd)
//  WIDTH         32    data width in bits, >=1
//  DEPTH         1024  storage words; power of two, >=4
//  AFULL_THRESH  DEPTH-4  almost_full asserts when count >= AFULL_THRESH; legal 1..DEPTH
//  AEMPTY_THRESH 4     almost_empty asserts when count <= AEMPTY_THRESH; legal 0..DEPTH-1
// PORTS
//  clk           in   1              clock, all logic rising-edge
//  rst_n         in   1              asynchronous active-low reset
//  flush         in   1              synchronous clear of contents (pulse)
//  wr            in   1              write request
//  din           in   WIDTH          write data
//  full          out  1              no free slot; wr ignored
//  almost_full   out  1              count >= AFULL_THRESH
//  rd            in   1              read/pop request
//  dout          out  WIDTH          read data
//  dvld          out  1              dout valid
//  empty         out  1              no word available to rd
//  almost_empty  out  1              count <= AEMPTY_THRESH
//  count         out  $clog2(DEPTH)+1  words written and not yet popped, 0..DEPTH
//  clr_err       in   1              clears overflow/underflow (pulse)
//  overflow      out  1              sticky: wr while full
//  underflow     out  1              sticky: rd while empty
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync deassert externally): count=0, empty=1, almost_empty=1, full=0,
//    almost_full=0, dvld=0, dout=0, overflow=0, underflow=0. Reset mid-transfer discards all content.
//  - Pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); MSB is wrap flag; addresses wrap DEPTH-1 -> 0 naturally.
//  - Accepted write: wr & ~full. Accepted read: rd & ~empty. Flags sampled pre-edge (no same-cycle credit).
//  - count: +1 on accepted write, -1 on accepted read, unchanged when both; full = (count==DEPTH).
//  - FWFT=1: internal prefetch output register counts toward count and capacity (total DEPTH words).
//    empty = ~dvld. Write into empty FIFO at edge E -> dvld=1, dout=din after edge E+2.
//    rd with dvld=1 pops at the edge; next word presented next cycle if stored (1 word/cycle sustained).
//    dout holds stable while dvld=1 and rd=0.
//  - FWFT=0: empty = (count==0). Accepted rd at edge E -> dout valid, dvld=1 for one cycle after edge E.
//    dout holds last read word otherwise; dvld=0 when no accepted rd.
//  - Rejected wr (full): data dropped, count unchanged, overflow<=1. Rejected rd (empty): underflow<=1.
//  - Simultaneous wr&rd when full: rd accepted, wr rejected (overflow set). When empty: wr accepted, rd rejected.
//  - flush: at edge, pointers/count/prefetch cleared, dvld<=0, empty<=1; overrides wr/rd same cycle;
//    overflow/underflow NOT affected. clr_err clears both sticky flags; a new error same cycle wins (flag stays 1).
//  - almost_* derived combinationally from count; all status outputs glitch-free registered-count based.
// TESTING
//  1 Reset: hold rst_n=0 mid-stream -> all outputs at reset values immediately; count=0 after release.
//  2 FWFT=1,DEPTH=16: write 0xA5 into empty at edge 0 -> dvld=1,dout=0xA5 after edge 2; rd -> empty=1, count=0.
//  3 Fill DEPTH=16 with 0..15 -> full=1,count=16, almost_full from count 12; extra wr 0xFF -> overflow=1,
//    drain reads 0..15 in order, 0xFF never appears; almost_empty asserts at count<=4.
//  4 Continuous wr&rd for 3*DEPTH cycles (wrap) -> in-order data, 1 word/cycle, count constant.
//  5 FWFT=0: write 7,8; rd at edge E -> dout=7,dvld=1 after E; rd on empty -> underflow=1; clr_err -> 0.
//  6 Write 5 words then flush with wr=1 same cycle -> count=0,empty=1,dvld=0, sticky flags unchanged.

Source files
------------

// File: rtl/fifo_flow_if.sv
// Handshake bundle between a FIFO producer/consumer and fifo_flow.
// The master drives write/read requests; the slave reports data and status.
interface fifo_flow_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1024
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             flush;
   logic             wr;
   logic [WIDTH-1:0] din;
   logic             full;
   logic             almost_full;
   logic             rd;
   logic [WIDTH-1:0] dout;
   logic             dvld;
   logic             empty;
   logic             almost_empty;
   logic [CNT_W-1:0] count;
   logic             clr_err;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, wr, din, rd, clr_err,
      input  full, almost_full, dout, dvld, empty, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, wr, din, rd, clr_err,
      output full, almost_full, dout, dvld, empty, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_flow.sv
// Single-clock FIFO on a sync-read RAM with FWFT or standard read mode,
// occupancy count, almost thresholds, sticky error flags and synchronous flush.
module fifo_flow #(
   parameter bit          FWFT          = 1'b1,
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned DEPTH         = 1024,
   parameter int unsigned AFULL_THRESH  = DEPTH - 4,
   parameter int unsigned AEMPTY_THRESH = 4
) (
   input logic          clk,
   input logic          rst_n,
   fifo_flow_if.slave   bus
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] ram_q, ram_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ram_vld_q, ram_vld_d;
   logic             dvld_q, dvld_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic wr_acc, rd_acc, mem_has, ram_re, ram_move;

   // Next-state: RAM read stage (ram_q) feeds the output register in FWFT mode;
   // in standard mode ram_q is the output and only loads on an accepted read.
   always_comb begin
      wr_acc    = bus.wr & ~full_q & ~bus.flush;
      rd_acc    = bus.rd & ~empty_q & ~bus.flush;
      mem_has   = (wptr_q != rptr_q);
      ram_move  = 1'b0;
      ram_re    = 1'b0;
      ram_vld_d = ram_vld_q;
      dvld_d    = 1'b0;
      dout_d    = dout_q;

      if (FWFT) begin
         ram_move  = ram_vld_q & (~dvld_q | rd_acc);
         ram_re    = mem_has & (~ram_vld_q | ram_move);
         ram_vld_d = ram_re | (ram_vld_q & ~ram_move);
         dvld_d    = ram_move | (dvld_q & ~rd_acc);
         if (ram_move) dout_d = ram_q;
      end else begin
         ram_re    = rd_acc;
         ram_vld_d = 1'b0;
         dvld_d    = rd_acc;
      end

      ram_d   = ram_re ? mem[rptr_q[ADDR_W-1:0]] : ram_q;
      wptr_d  = wptr_q + PTR_W'(wr_acc);
      rptr_d  = rptr_q + PTR_W'(ram_re);
      count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

      if (bus.flush) begin
         wptr_d    = '0;
         rptr_d    = '0;
         count_d   = '0;
         ram_vld_d = 1'b0;
         dvld_d    = 1'b0;
         ram_d     = ram_q;
         dout_d    = dout_q;
      end

      full_d      = (count_d == CNT_W'(DEPTH));
      empty_d     = FWFT ? ~dvld_d : (count_d == '0);
      afull_d     = (count_d >= CNT_W'(AFULL_THRESH));
      aempty_d    = (count_d <= CNT_W'(AEMPTY_THRESH));
      // A fresh error in the same cycle as clr_err keeps the flag set.
      overflow_d  = (overflow_q & ~bus.clr_err) | (bus.wr & full_q & ~bus.flush);
      underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd & empty_q & ~bus.flush);
   end

   // Storage array: write port only, no reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr_q[ADDR_W-1:0]] <= bus.din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         ram_q       <= '0;
         dout_q      <= '0;
         ram_vld_q   <= 1'b0;
         dvld_q      <= 1'b0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         ram_q       <= ram_d;
         dout_q      <= dout_d;
         ram_vld_q   <= ram_vld_d;
         dvld_q      <= dvld_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         afull_q     <= afull_d;
         aempty_q    <= aempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.dout         = FWFT ? dout_q : ram_q;
   assign bus.dvld         = dvld_q;
   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_flow.sv
// Bench for fifo_flow: one FWFT and one standard-mode instance (WIDTH=8, DEPTH=16),
// data ordering checked against a queue scoreboard.
module tb_fifo_flow;
   localparam int unsigned W  = 8;
   localparam int unsigned D  = 16;
   localparam int unsigned CW = 5;

   logic clk;
   logic rst_n;

   fifo_flow_if #(.WIDTH(W), .DEPTH(D)) bf ();
   fifo_flow_if #(.WIDTH(W), .DEPTH(D)) bs ();

   fifo_flow #(.FWFT(1'b1), .WIDTH(W), .DEPTH(D), .AFULL_THRESH(12), .AEMPTY_THRESH(4))
      u_fwft (.clk(clk), .rst_n(rst_n), .bus(bf));
   fifo_flow #(.FWFT(1'b0), .WIDTH(W), .DEPTH(D), .AFULL_THRESH(12), .AEMPTY_THRESH(4))
      u_std (.clk(clk), .rst_n(rst_n), .bus(bs));

   int          n_chk  = 0;
   int          n_fail = 0;
   int          mcnt   = 0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] front;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bf.flush = 0; bf.wr = 0; bf.din = '0; bf.rd = 0; bf.clr_err = 0;
      bs.flush = 0; bs.wr = 0; bs.din = '0; bs.rd = 0; bs.clr_err = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      n_chk++;
      if ({bf.empty, bf.almost_empty, bf.full, bf.almost_full, bf.dvld, bf.overflow, bf.underflow} !== 7'b1100000) begin
         n_fail++; $display("FAIL reset_flags_fwft: got %b expected 1100000",
            {bf.empty, bf.almost_empty, bf.full, bf.almost_full, bf.dvld, bf.overflow, bf.underflow});
      end
      n_chk++;
      if ({bs.empty, bs.almost_empty, bs.full, bs.almost_full, bs.dvld, bs.overflow, bs.underflow} !== 7'b1100000) begin
         n_fail++; $display("FAIL reset_flags_std: got %b expected 1100000",
            {bs.empty, bs.almost_empty, bs.full, bs.almost_full, bs.dvld, bs.overflow, bs.underflow});
      end
      n_chk++;
      if (bf.count !== CW'(0) || bf.dout !== W'(0) || bs.count !== CW'(0) || bs.dout !== W'(0)) begin
         n_fail++; $display("FAIL reset_count_dout: fwft cnt=%0d dout=%0h std cnt=%0d dout=%0h expected all 0",
            bf.count, bf.dout, bs.count, bs.dout);
      end
      rst_n = 1'b1;
      // Reset asserted asynchronously while the FWFT instance holds data.
      for (int i = 0; i < 3; i++) begin
         bf.wr = 1; bf.din = W'(8'h30 + i);
         @(negedge clk);
      end
      bf.wr = 0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (bf.dvld !== 1'b1 || bf.count !== CW'(3)) begin
         n_fail++; $display("FAIL pre_reset_fill: dvld=%b cnt=%0d expected dvld=1 cnt=3", bf.dvld, bf.count);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_chk++;
      if (bf.count !== CW'(0) || bf.dvld !== 1'b0 || bf.empty !== 1'b1 || bf.dout !== W'(0)) begin
         n_fail++; $display("FAIL async_reset: cnt=%0d dvld=%b empty=%b dout=%0h expected 0/0/1/0",
            bf.count, bf.dvld, bf.empty, bf.dout);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if (bf.count !== CW'(0) || bf.dvld !== 1'b0 || bf.empty !== 1'b1) begin
         n_fail++; $display("FAIL post_reset: cnt=%0d dvld=%b empty=%b expected 0/0/1", bf.count, bf.dvld, bf.empty);
      end
      exp_q.delete();
      mcnt = 0;
   endtask

   task automatic test_fwft_latency();
      bf.wr = 1; bf.din = 8'hA5; exp_q.push_back(8'hA5);
      @(negedge clk);
      bf.wr = 0;
      n_chk++;
      if (bf.dvld !== 1'b0 || bf.count !== CW'(1)) begin
         n_fail++; $display("FAIL lat_edge0: dvld=%b cnt=%0d expected 0/1", bf.dvld, bf.count);
      end
      @(negedge clk);
      n_chk++;
      if (bf.dvld !== 1'b0) begin
         n_fail++; $display("FAIL lat_edge1: dvld=%b expected 0", bf.dvld);
      end
      @(negedge clk);
      front = exp_q.pop_front();
      n_chk++;
      if (bf.dvld !== 1'b1 || bf.dout !== front || bf.empty !== 1'b0) begin
         n_fail++; $display("FAIL lat_edge2: dvld=%b dout=%0h empty=%b expected 1/%0h/0", bf.dvld, bf.dout, bf.empty, front);
      end
      bf.rd = 1;
      @(negedge clk);
      bf.rd = 0;
      n_chk++;
      if (bf.empty !== 1'b1 || bf.count !== CW'(0) || bf.dvld !== 1'b0 || bf.underflow !== 1'b0) begin
         n_fail++; $display("FAIL lat_pop: empty=%b cnt=%0d dvld=%b unf=%b expected 1/0/0/0",
            bf.empty, bf.count, bf.dvld, bf.underflow);
      end
   endtask

   task automatic test_fill();
      mcnt = 0;
      for (int i = 0; i < 16; i++) begin
         bf.wr = 1; bf.din = W'(i); exp_q.push_back(W'(i));
         @(negedge clk);
         mcnt++;
         n_chk++;
         if (bf.count !== CW'(mcnt) || bf.almost_full !== (mcnt >= 12) || bf.full !== (mcnt == 16)
             || bf.almost_empty !== (mcnt <= 4)) begin
            n_fail++; $display("FAIL fill_%0d: cnt=%0d af=%b full=%b ae=%b expected cnt=%0d af=%b full=%b ae=%b",
               i, bf.count, bf.almost_full, bf.full, bf.almost_empty, mcnt, (mcnt >= 12), (mcnt == 16), (mcnt <= 4));
         end
      end
      bf.din = 8'hFF;
      @(negedge clk);
      bf.wr = 0;
      n_chk++;
      if (bf.overflow !== 1'b1 || bf.count !== CW'(16) || bf.full !== 1'b1) begin
         n_fail++; $display("FAIL overflow_set: ovf=%b cnt=%0d full=%b expected 1/16/1", bf.overflow, bf.count, bf.full);
      end
      bf.clr_err = 1;
      @(negedge clk);
      bf.clr_err = 0;
      n_chk++;
      if (bf.overflow !== 1'b0) begin
         n_fail++; $display("FAIL overflow_clr: ovf=%b expected 0", bf.overflow);
      end
      // Simultaneous wr&rd while full: read wins, write dropped.
      front = exp_q.pop_front();
      n_chk++;
      if (bf.dvld !== 1'b1 || bf.dout !== front) begin
         n_fail++; $display("FAIL full_head: dvld=%b dout=%0h expected 1/%0h", bf.dvld, bf.dout, front);
      end
      bf.wr = 1; bf.din = 8'hEE; bf.rd = 1;
      @(negedge clk);
      bf.wr = 0; bf.rd = 0;
      mcnt = 15;
      n_chk++;
      if (bf.count !== CW'(15) || bf.overflow !== 1'b1 || bf.full !== 1'b0) begin
         n_fail++; $display("FAIL full_wr_rd: cnt=%0d ovf=%b full=%b expected 15/1/0", bf.count, bf.overflow, bf.full);
      end
      bf.clr_err = 1;
      @(negedge clk);
      bf.clr_err = 0;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
         n_chk++;
         if (bf.count !== CW'(mcnt) || bf.almost_empty !== (mcnt <= 4) || bf.almost_full !== (mcnt >= 12)) begin
            n_fail++; $display("FAIL drain_status_%0d: cnt=%0d ae=%b af=%b expected cnt=%0d ae=%b af=%b",
               k, bf.count, bf.almost_empty, bf.almost_full, mcnt, (mcnt <= 4), (mcnt >= 12));
         end
         if (bf.dvld === 1'b1) begin
            front = exp_q.pop_front();
            n_chk++;
            if (bf.dout !== front) begin
               n_fail++; $display("FAIL drain_data_%0d: dout=%0h expected %0h", k, bf.dout, front);
            end
            bf.rd = 1;
            mcnt--;
         end else begin
            bf.rd = 0;
         end
         @(negedge clk);
      end
      bf.rd = 0;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL drain_timeout: %0d words left expected 0", exp_q.size());
         exp_q.delete();
      end
      n_chk++;
      if (bf.count !== CW'(0) || bf.empty !== 1'b1 || bf.underflow !== 1'b0 || bf.overflow !== 1'b0) begin
         n_fail++; $display("FAIL drain_end: cnt=%0d empty=%b unf=%b ovf=%b expected 0/1/0/0",
            bf.count, bf.empty, bf.underflow, bf.overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] nxt;
      nxt = 8'h40;
      for (int i = 0; i < 4; i++) begin
         bf.wr = 1; bf.din = nxt; exp_q.push_back(nxt); nxt++;
         @(negedge clk);
      end
      bf.wr = 0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 3 * D; c++) begin
         front = exp_q.pop_front();
         n_chk++;
         if (bf.dvld !== 1'b1 || bf.count !== CW'(4) || bf.dout !== front) begin
            n_fail++; $display("FAIL stream_%0d: dvld=%b cnt=%0d dout=%0h expected 1/4/%0h",
               c, bf.dvld, bf.count, bf.dout, front);
         end
         bf.wr = 1; bf.din = nxt; exp_q.push_back(nxt); nxt++;
         bf.rd = 1;
         @(negedge clk);
      end
      bf.wr = 0; bf.rd = 0;
      bf.flush = 1;
      @(negedge clk);
      bf.flush = 0;
      exp_q.delete();
      mcnt = 0;
   endtask

   task automatic test_std();
      bs.wr = 1; bs.din = 8'h07; exp_q.push_back(8'h07);
      @(negedge clk);
      bs.din = 8'h08; exp_q.push_back(8'h08);
      @(negedge clk);
      bs.wr = 0;
      n_chk++;
      if (bs.dvld !== 1'b0 || bs.count !== CW'(2) || bs.empty !== 1'b0) begin
         n_fail++; $display("FAIL std_loaded: dvld=%b cnt=%0d empty=%b expected 0/2/0", bs.dvld, bs.count, bs.empty);
      end
      for (int i = 0; i < 2; i++) begin
         bs.rd = 1;
         @(negedge clk);
         front = exp_q.pop_front();
         n_chk++;
         if (bs.dvld !== 1'b1 || bs.dout !== front || bs.count !== CW'(1 - i)) begin
            n_fail++; $display("FAIL std_rd_%0d: dvld=%b dout=%0h cnt=%0d expected 1/%0h/%0d",
               i, bs.dvld, bs.dout, bs.count, front, 1 - i);
         end
      end
      bs.rd = 0;
      @(negedge clk);
      n_chk++;
      if (bs.dvld !== 1'b0 || bs.dout !== 8'h08 || bs.empty !== 1'b1) begin
         n_fail++; $display("FAIL std_hold: dvld=%b dout=%0h empty=%b expected 0/08/1", bs.dvld, bs.dout, bs.empty);
      end
      bs.rd = 1;
      @(negedge clk);
      bs.rd = 0;
      n_chk++;
      if (bs.underflow !== 1'b1 || bs.dvld !== 1'b0) begin
         n_fail++; $display("FAIL std_underflow: unf=%b dvld=%b expected 1/0", bs.underflow, bs.dvld);
      end
      bs.rd = 1; bs.clr_err = 1;
      @(negedge clk);
      bs.rd = 0;
      n_chk++;
      if (bs.underflow !== 1'b1) begin
         n_fail++; $display("FAIL std_err_wins: unf=%b expected 1", bs.underflow);
      end
      @(negedge clk);
      bs.clr_err = 0;
      n_chk++;
      if (bs.underflow !== 1'b0) begin
         n_fail++; $display("FAIL std_clr: unf=%b expected 0", bs.underflow);
      end
      // wr&rd on empty: write accepted, read rejected.
      bs.wr = 1; bs.din = 8'h09; bs.rd = 1; exp_q.push_back(8'h09);
      @(negedge clk);
      bs.wr = 0; bs.rd = 0;
      n_chk++;
      if (bs.count !== CW'(1) || bs.underflow !== 1'b1 || bs.dvld !== 1'b0) begin
         n_fail++; $display("FAIL std_empty_wr_rd: cnt=%0d unf=%b dvld=%b expected 1/1/0", bs.count, bs.underflow, bs.dvld);
      end
      bs.rd = 1; bs.clr_err = 1;
      @(negedge clk);
      bs.rd = 0; bs.clr_err = 0;
      front = exp_q.pop_front();
      n_chk++;
      if (bs.dvld !== 1'b1 || bs.dout !== front || bs.count !== CW'(0) || bs.underflow !== 1'b0) begin
         n_fail++; $display("FAIL std_last: dvld=%b dout=%0h cnt=%0d unf=%b expected 1/%0h/0/0",
            bs.dvld, bs.dout, bs.count, bs.underflow, front);
      end
   endtask

   task automatic test_flush();
      bf.rd = 1;
      @(negedge clk);
      bf.rd = 0;
      n_chk++;
      if (bf.underflow !== 1'b1) begin
         n_fail++; $display("FAIL flush_pre_unf: unf=%b expected 1", bf.underflow);
      end
      for (int i = 0; i < 5; i++) begin
         bf.wr = 1; bf.din = W'(8'h60 + i);
         @(negedge clk);
      end
      bf.wr = 0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (bf.count !== CW'(5) || bf.dvld !== 1'b1) begin
         n_fail++; $display("FAIL flush_pre_cnt: cnt=%0d dvld=%b expected 5/1", bf.count, bf.dvld);
      end
      bf.flush = 1; bf.wr = 1; bf.din = 8'h77;
      @(negedge clk);
      bf.flush = 0; bf.wr = 0;
      n_chk++;
      if (bf.count !== CW'(0) || bf.empty !== 1'b1 || bf.dvld !== 1'b0 || bf.underflow !== 1'b1 || bf.overflow !== 1'b0) begin
         n_fail++; $display("FAIL flush: cnt=%0d empty=%b dvld=%b unf=%b ovf=%b expected 0/1/0/1/0",
            bf.count, bf.empty, bf.dvld, bf.underflow, bf.overflow);
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (bf.count !== CW'(0) || bf.dvld !== 1'b0) begin
         n_fail++; $display("FAIL flush_settle: cnt=%0d dvld=%b expected 0/0", bf.count, bf.dvld);
      end
      bf.wr = 1; bf.din = 8'h5A; exp_q.push_back(8'h5A);
      @(negedge clk);
      bf.wr = 0;
      repeat (2) @(negedge clk);
      front = exp_q.pop_front();
      n_chk++;
      if (bf.dvld !== 1'b1 || bf.dout !== front || bf.count !== CW'(1)) begin
         n_fail++; $display("FAIL flush_reuse: dvld=%b dout=%0h cnt=%0d expected 1/%0h/1", bf.dvld, bf.dout, bf.count, front);
      end
   endtask

   initial begin
      test_reset();
      test_fwft_latency();
      test_fill();
      test_back_to_back();
      test_std();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
